// File: rtl/mult_pipeline.sv
// mult_pipeline: four-stage (S2..S5) integer multiply unit for the M-extension
// MUL, MULH, MULHSU and MULHU operations.
//
// Stage contents:
//   S2: sampled request plus operands extended to 33 bits.
//   S3: four partial products of a 16/17-bit split of each operand.
//   S4: low 64 bits of the summed product.
//   S5: selected 32-bit result. The wb_* outputs are driven straight from S5.
//
// Ports:
//   clk_i                single clock, all state on the rising edge
//   rsn_i                asynchronous active-low reset
//   mult1_valid_i        mult1 holds a multiply
//   mult1_write_addr_i   destination register
//   mult1_rs1_data_i     operand 1
//   mult1_rs2_data_i     operand 2
//   mult1_instruction_i  instruction word (funct3 selects the operation)
//   mult1_pc_i           PC, carried to writeback
//   stall_i              freeze every stage
//   flush_i              kill in-flight ops (takes priority over stall_i)
//   wb_valid_o           writeback request, one cycle per op
//   wb_write_addr_o      writeback destination register
//   wb_write_data_o      writeback data
//   wb_instruction_o     instruction word of the written-back op
//   wb_pc_o              PC of the written-back op
//   stage_valid_o        valid bits of S2..S5 (bit 0 = S2)
//   stage_addr_o         destination addresses of S2..S5 (bits 4:0 = S2)
//   busy_o               any stage holds a valid op
module mult_pipeline (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        mult1_valid_i,
    input  logic [4:0]  mult1_write_addr_i,
    input  logic [31:0] mult1_rs1_data_i,
    input  logic [31:0] mult1_rs2_data_i,
    input  logic [31:0] mult1_instruction_i,
    input  logic [31:0] mult1_pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_write_addr_o,
    output logic [31:0] wb_write_data_o,
    output logic [31:0] wb_instruction_o,
    output logic [31:0] wb_pc_o,
    output logic [3:0]  stage_valid_o,
    output logic [19:0] stage_addr_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhsu = 2'b10,
        OpMulhu  = 2'b11
    } mul_op_e;

    // ------------------------------------------------------------------
    // S2 input decode
    // ------------------------------------------------------------------
    logic [2:0]  funct3;
    mul_op_e     op_in;
    logic        rs1_signed;
    logic        rs2_signed;
    logic        s2_valid_d;
    logic [32:0] s2_a_d;
    logic [32:0] s2_b_d;

    always_comb begin
        funct3     = mult1_instruction_i[14:12];
        op_in      = mul_op_e'(funct3[1:0]);
        rs1_signed = (op_in == OpMulh) || (op_in == OpMulhsu);
        rs2_signed = (op_in == OpMulh);
        // funct3[2]=1 is a divide/remainder op, not ours: load a bubble.
        s2_valid_d = mult1_valid_i & ~funct3[2];
        s2_a_d     = {rs1_signed & mult1_rs1_data_i[31], mult1_rs1_data_i};
        s2_b_d     = {rs2_signed & mult1_rs2_data_i[31], mult1_rs2_data_i};
    end

    logic        s2_valid_q;
    logic [4:0]  s2_addr_q;
    logic [31:0] s2_instr_q;
    logic [31:0] s2_pc_q;
    mul_op_e     s2_op_q;
    logic [32:0] s2_a_q;
    logic [32:0] s2_b_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_instr_q <= '0;
            s2_pc_q    <= '0;
            s2_op_q    <= OpMul;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
        end else if (flush_i) begin
            s2_valid_q <= 1'b0;
        end else if (!stall_i) begin
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= mult1_write_addr_i;
            s2_instr_q <= mult1_instruction_i;
            s2_pc_q    <= mult1_pc_i;
            s2_op_q    <= op_in;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
        end
    end

    // ------------------------------------------------------------------
    // S3: partial products
    // Each 33-bit operand x = x_hi * 2^17 + x_lo, x_hi signed 16 bits and
    // x_lo unsigned 17 bits. Operands are widened to 34 bits so every
    // product is exact at that width.
    // ------------------------------------------------------------------
    logic signed [33:0] a_hi_x;
    logic signed [33:0] a_lo_x;
    logic signed [33:0] b_hi_x;
    logic signed [33:0] b_lo_x;
    logic signed [33:0] pp_hh_full;
    logic [33:0]        s3_pp_ll_d;
    logic [33:0]        s3_pp_hl_d;
    logic [33:0]        s3_pp_lh_d;
    logic [31:0]        s3_pp_hh_d;

    always_comb begin
        a_hi_x     = {{18{s2_a_q[32]}}, s2_a_q[32:17]};
        a_lo_x     = {17'b0, s2_a_q[16:0]};
        b_hi_x     = {{18{s2_b_q[32]}}, s2_b_q[32:17]};
        b_lo_x     = {17'b0, s2_b_q[16:0]};
        s3_pp_ll_d = a_lo_x * b_lo_x;
        s3_pp_hl_d = a_hi_x * b_lo_x;
        s3_pp_lh_d = a_lo_x * b_hi_x;
        // hi*hi is at most 2^30 in magnitude, so 32 bits hold it exactly.
        pp_hh_full = a_hi_x * b_hi_x;
        s3_pp_hh_d = pp_hh_full[31:0];
    end

    logic        s3_valid_q;
    logic [4:0]  s3_addr_q;
    logic [31:0] s3_instr_q;
    logic [31:0] s3_pc_q;
    mul_op_e     s3_op_q;
    logic [33:0] s3_pp_ll_q;
    logic [33:0] s3_pp_hl_q;
    logic [33:0] s3_pp_lh_q;
    logic [31:0] s3_pp_hh_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            s3_valid_q <= 1'b0;
            s3_addr_q  <= '0;
            s3_instr_q <= '0;
            s3_pc_q    <= '0;
            s3_op_q    <= OpMul;
            s3_pp_ll_q <= '0;
            s3_pp_hl_q <= '0;
            s3_pp_lh_q <= '0;
            s3_pp_hh_q <= '0;
        end else if (flush_i) begin
            s3_valid_q <= 1'b0;
        end else if (!stall_i) begin
            s3_valid_q <= s2_valid_q;
            s3_addr_q  <= s2_addr_q;
            s3_instr_q <= s2_instr_q;
            s3_pc_q    <= s2_pc_q;
            s3_op_q    <= s2_op_q;
            s3_pp_ll_q <= s3_pp_ll_d;
            s3_pp_hl_q <= s3_pp_hl_d;
            s3_pp_lh_q <= s3_pp_lh_d;
            s3_pp_hh_q <= s3_pp_hh_d;
        end
    end

    // ------------------------------------------------------------------
    // S4: sum of partial products. Only bits 63:0 of the 66-bit product
    // are ever selected, so the sum is carried modulo 2^64.
    // ------------------------------------------------------------------
    logic [63:0] ll_ext;
    logic [63:0] hl_ext;
    logic [63:0] lh_ext;
    logic [63:0] hh_ext;
    logic [63:0] s4_prod_d;

    always_comb begin
        ll_ext    = {30'b0, s3_pp_ll_q};
        hl_ext    = {{30{s3_pp_hl_q[33]}}, s3_pp_hl_q};
        lh_ext    = {{30{s3_pp_lh_q[33]}}, s3_pp_lh_q};
        hh_ext    = {{32{s3_pp_hh_q[31]}}, s3_pp_hh_q};
        s4_prod_d = ll_ext + (hl_ext << 17) + (lh_ext << 17) + (hh_ext << 34);
    end

    logic        s4_valid_q;
    logic [4:0]  s4_addr_q;
    logic [31:0] s4_instr_q;
    logic [31:0] s4_pc_q;
    mul_op_e     s4_op_q;
    logic [63:0] s4_prod_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            s4_valid_q <= 1'b0;
            s4_addr_q  <= '0;
            s4_instr_q <= '0;
            s4_pc_q    <= '0;
            s4_op_q    <= OpMul;
            s4_prod_q  <= '0;
        end else if (flush_i) begin
            s4_valid_q <= 1'b0;
        end else if (!stall_i) begin
            s4_valid_q <= s3_valid_q;
            s4_addr_q  <= s3_addr_q;
            s4_instr_q <= s3_instr_q;
            s4_pc_q    <= s3_pc_q;
            s4_op_q    <= s3_op_q;
            s4_prod_q  <= s4_prod_d;
        end
    end

    // ------------------------------------------------------------------
    // S5: result select and writeback register
    // ------------------------------------------------------------------
    logic [31:0] s5_data_d;

    always_comb begin
        s5_data_d = (s4_op_q == OpMul) ? s4_prod_q[31:0] : s4_prod_q[63:32];
    end

    logic        s5_valid_q;
    logic [4:0]  s5_addr_q;
    logic [31:0] s5_instr_q;
    logic [31:0] s5_pc_q;
    logic [31:0] s5_data_q;

    // On flush S5 still advances, but the op leaving S4 is killed too.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            s5_valid_q <= 1'b0;
            s5_addr_q  <= '0;
            s5_instr_q <= '0;
            s5_pc_q    <= '0;
            s5_data_q  <= '0;
        end else if (flush_i || !stall_i) begin
            s5_valid_q <= s4_valid_q & ~flush_i;
            s5_addr_q  <= s4_addr_q;
            s5_instr_q <= s4_instr_q;
            s5_pc_q    <= s4_pc_q;
            s5_data_q  <= s5_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        wb_valid_o       = s5_valid_q;
        wb_write_addr_o  = s5_addr_q;
        wb_write_data_o  = s5_data_q;
        wb_instruction_o = s5_instr_q;
        wb_pc_o          = s5_pc_q;
        stage_valid_o    = {s5_valid_q, s4_valid_q, s3_valid_q, s2_valid_q};
        stage_addr_o     = {s5_addr_q, s4_addr_q, s3_addr_q, s2_addr_q};
        busy_o           = |stage_valid_o;
    end

endmodule

// File: tb/tb_mult_pipeline.sv
// Self-checking bench for mult_pipeline. Stimulus pushes the expected
// writeback into a queue; a monitor pops and compares on every wb_valid_o.
module tb_mult_pipeline;

    logic        clk_i;
    logic        rsn_i;
    logic        mult1_valid_i;
    logic [4:0]  mult1_write_addr_i;
    logic [31:0] mult1_rs1_data_i;
    logic [31:0] mult1_rs2_data_i;
    logic [31:0] mult1_instruction_i;
    logic [31:0] mult1_pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        wb_valid_o;
    logic [4:0]  wb_write_addr_o;
    logic [31:0] wb_write_data_o;
    logic [31:0] wb_instruction_o;
    logic [31:0] wb_pc_o;
    logic [3:0]  stage_valid_o;
    logic [19:0] stage_addr_o;
    logic        busy_o;

    mult_pipeline u_dut (
        .clk_i               (clk_i),
        .rsn_i               (rsn_i),
        .mult1_valid_i       (mult1_valid_i),
        .mult1_write_addr_i  (mult1_write_addr_i),
        .mult1_rs1_data_i    (mult1_rs1_data_i),
        .mult1_rs2_data_i    (mult1_rs2_data_i),
        .mult1_instruction_i (mult1_instruction_i),
        .mult1_pc_i          (mult1_pc_i),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .wb_valid_o          (wb_valid_o),
        .wb_write_addr_o     (wb_write_addr_o),
        .wb_write_data_o     (wb_write_data_o),
        .wb_instruction_o    (wb_instruction_o),
        .wb_pc_o             (wb_pc_o),
        .stage_valid_o       (stage_valid_o),
        .stage_addr_o        (stage_addr_o),
        .busy_o              (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] instr;
        logic [31:0] pc;
    } wb_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        push;
        logic [31:0] exp;
    } vec_t;

    localparam int NVec = 17;

    wb_t         exp_q[$];
    wb_t         mon_exp;
    vec_t        vecs[NVec];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic        held = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic push,
                         input logic [31:0] exp_data);
        wb_t item;
        mult1_valid_i       = v;
        mult1_write_addr_i  = rd;
        mult1_rs1_data_i    = a;
        mult1_rs2_data_i    = b;
        mult1_instruction_i = mk_instr(f3, rd);
        mult1_pc_i          = pc_ctr;
        if (push) begin
            item.addr  = rd;
            item.data  = exp_data;
            item.instr = mk_instr(f3, rd);
            item.pc    = pc_ctr;
            exp_q.push_back(item);
        end
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic drive_idle();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Remember whether the last edge held the pipeline, so a writeback held
    // over a stall is not counted twice.
    always @(posedge clk_i) held <= rsn_i && stall_i && !flush_i;

    always @(negedge clk_i) begin
        if (rsn_i && wb_valid_o && !held) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: got addr %0d data %h, expected no writeback",
                         wb_write_addr_o, wb_write_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("wb_scoreboard",
                    128'({wb_write_addr_o, wb_write_data_o, wb_instruction_o, wb_pc_o}),
                    128'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000},
            '{1'b1, 3'b010, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hC000_0000},
            '{1'b1, 3'b011, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000},
            '{1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF},
            '{1'b1, 3'b100, 32'h0000_0009, 32'h0000_0003, 1'b0, 32'h0},
            '{1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE},
            '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001},
            '{1'b0, 3'b000, 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0},
            '{1'b1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000},
            '{1'b1, 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF},
            '{1'b1, 3'b000, 32'h0001_FFFF, 32'h0001_FFFF, 1'b1, 32'hFFFC_0001},
            '{1'b1, 3'b011, 32'h0001_FFFF, 32'h0001_FFFF, 1'b1, 32'h0000_0003},
            '{1'b1, 3'b010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFE},
            '{1'b1, 3'b111, 32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0},
            '{1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF},
            '{1'b1, 3'b000, 32'h1234_5678, 32'h0000_0010, 1'b1, 32'h2345_6780},
            '{1'b1, 3'b011, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001}
        };

        rsn_i   = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive_idle();
        #1 rsn_i = 1'b0;
        #2;
        chk("rst_wb_valid", 128'(wb_valid_o), 128'(1'b0));
        chk("rst_wb_addr", 128'(wb_write_addr_o), 128'(5'd0));
        chk("rst_wb_data", 128'(wb_write_data_o), 128'(32'h0));
        chk("rst_wb_instr", 128'(wb_instruction_o), 128'(32'h0));
        chk("rst_wb_pc", 128'(wb_pc_o), 128'(32'h0));
        chk("rst_stage_valid", 128'(stage_valid_o), 128'(4'h0));
        chk("rst_stage_addr", 128'(stage_addr_o), 128'(20'h0));
        chk("rst_busy", 128'(busy_o), 128'(1'b0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rsn_i = 1'b1;

        // Single MUL, latency and stage tracking.
        drive(1'b1, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB);
        tick();
        drive_idle();
        chk("mul_s2_valid", 128'(stage_valid_o), 128'(4'b0001));
        chk("mul_s2_addr", 128'(stage_addr_o), 128'(20'h00005));
        chk("mul_busy", 128'(busy_o), 128'(1'b1));
        tick();
        chk("mul_s3_valid", 128'(stage_valid_o), 128'(4'b0010));
        tick();
        chk("mul_s4_valid", 128'(stage_valid_o), 128'(4'b0100));
        chk("mul_no_early_wb", 128'(wb_valid_o), 128'(1'b0));
        tick();
        chk("mul_wb_valid", 128'(wb_valid_o), 128'(1'b1));
        chk("mul_wb_addr", 128'(wb_write_addr_o), 128'(5'd5));
        chk("mul_wb_data", 128'(wb_write_data_o), 128'(32'hFFFF_FFEB));
        tick();
        chk("mul_wb_pulse", 128'(wb_valid_o), 128'(1'b0));
        chk("mul_idle_busy", 128'(busy_o), 128'(1'b0));

        // Back-to-back directed vectors, including bubbles and non-mul ops.
        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].v, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].push,
                  vecs[i].exp);
            tick();
        end
        drive_idle();
        repeat (5) tick();
        chk("b2b_drain", 128'(exp_q.size()), 128'(0));

        // Stall for two edges while a second op is offered and must be ignored.
        drive(1'b1, 3'b000, 32'h0000_0003, 32'h0000_0004, 5'd9, 1'b1, 32'h0000_000C);
        tick();
        stall_i = 1'b1;
        drive(1'b1, 3'b000, 32'h0000_0005, 32'h0000_0005, 5'd10, 1'b0, 32'h0);
        tick();
        chk("stall_valid_1", 128'(stage_valid_o), 128'(4'b0001));
        chk("stall_addr_1", 128'(stage_addr_o), 128'(20'h00009));
        tick();
        chk("stall_valid_2", 128'(stage_valid_o), 128'(4'b0001));
        chk("stall_no_wb", 128'(wb_valid_o), 128'(1'b0));
        stall_i = 1'b0;
        drive_idle();
        tick();
        chk("stall_resume", 128'(stage_valid_o), 128'(4'b0010));
        tick();
        tick();
        chk("stall_wb_valid", 128'(wb_valid_o), 128'(1'b1));
        chk("stall_wb_data", 128'(wb_write_data_o), 128'(32'h0000_000C));
        stall_i = 1'b1;
        tick();
        chk("stall_wb_hold_valid", 128'(wb_valid_o), 128'(1'b1));
        chk("stall_wb_hold_data", 128'(wb_write_data_o), 128'(32'h0000_000C));
        chk("stall_wb_hold_addr", 128'(wb_write_addr_o), 128'(5'd9));
        stall_i = 1'b0;
        tick();
        chk("stall_wb_done", 128'(wb_valid_o), 128'(1'b0));
        chk("stall_drain", 128'(exp_q.size()), 128'(0));

        // Flush with three ops in flight; flush also overrides a stall.
        drive(1'b1, 3'b000, 32'h0000_0002, 32'h0000_0003, 5'd11, 1'b0, 32'h0);
        tick();
        drive(1'b1, 3'b001, 32'h0000_0002, 32'h0000_0003, 5'd12, 1'b0, 32'h0);
        tick();
        drive(1'b1, 3'b011, 32'h0000_0002, 32'h0000_0003, 5'd13, 1'b0, 32'h0);
        tick();
        chk("flush_pre_valid", 128'(stage_valid_o), 128'(4'b0111));
        flush_i = 1'b1;
        stall_i = 1'b1;
        drive(1'b1, 3'b000, 32'h0000_0004, 32'h0000_0004, 5'd14, 1'b0, 32'h0);
        tick();
        flush_i = 1'b0;
        stall_i = 1'b0;
        drive_idle();
        chk("flush_busy", 128'(busy_o), 128'(1'b0));
        chk("flush_stage_valid", 128'(stage_valid_o), 128'(4'h0));
        chk("flush_no_wb", 128'(wb_valid_o), 128'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", 128'(wb_valid_o), 128'(1'b0));
        end
        drive(1'b1, 3'b000, 32'h0000_0006, 32'h0000_0007, 5'd15, 1'b1, 32'h0000_002A);
        tick();
        drive_idle();
        repeat (4) tick();
        chk("flush_drain", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset with two ops in flight.
        drive(1'b1, 3'b000, 32'h0000_0009, 32'h0000_0009, 5'd16, 1'b0, 32'h0);
        tick();
        drive(1'b1, 3'b010, 32'h0000_0009, 32'h0000_0009, 5'd17, 1'b0, 32'h0);
        tick();
        drive_idle();
        chk("rstmid_pre_valid", 128'(stage_valid_o), 128'(4'b0011));
        #1 rsn_i = 1'b0;
        #1;
        chk("rstmid_wb_valid", 128'(wb_valid_o), 128'(1'b0));
        chk("rstmid_wb_addr", 128'(wb_write_addr_o), 128'(5'd0));
        chk("rstmid_wb_data", 128'(wb_write_data_o), 128'(32'h0));
        chk("rstmid_stage_valid", 128'(stage_valid_o), 128'(4'h0));
        chk("rstmid_stage_addr", 128'(stage_addr_o), 128'(20'h0));
        chk("rstmid_busy", 128'(busy_o), 128'(1'b0));
        #1 rsn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstmid_quiet", 128'(wb_valid_o), 128'(1'b0));
        end
        drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1'b1, 32'hFFFF_FFFE);
        tick();
        drive_idle();
        repeat (5) tick();
        chk("final_drain", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_pipeline.md
MULT_PIPELINE -- requirements
Module: mult_pipeline

Interface
REQ-001 SHALL have: clk_i  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rsn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: mult1_valid_i  in  1  mult1 holds a multiply (the mult1 int write enable).
REQ-004 SHALL have: mult1_write_addr_i  in  5  destination register.
REQ-005 SHALL have: mult1_rs1_data_i / mult1_rs2_data_i  in  32 each  operands.
REQ-006 SHALL have: mult1_instruction_i / mult1_pc_i  in  32 each  instruction word and PC, carried to writeback.
REQ-007 SHALL have: stall_i  in  1  freeze all stages; flush_i  in  1  kill in-flight ops.
REQ-008 SHALL have: wb_valid_o  out 1, wb_write_addr_o  out 5, wb_write_data_o  out 32, wb_instruction_o  out 32, wb_pc_o  out 32: writeback request.
REQ-009 SHALL have: stage_valid_o  out 4  valid of S2..S5 (bit0=S2); stage_addr_o  out 20  dest addr of S2..S5 (bits 4:0=S2); busy_o  out 1  OR of stage_valid_o.

Function
REQ-010 SHALL implement four register stages S2,S3,S4,S5; each holds valid, addr, instruction, pc, op and datapath state.
REQ-011 SHALL sample mult1 inputs into S2 on a rising edge where stall_i=0 and flush_i=0; latency: op sampled at edge k drives wb_* after edge k+3.
REQ-012 SHALL decode op = mult1_instruction_i[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-013 SHALL accept into S2 only when mult1_valid_i=1 and op[2]=0; op[2]=1 loads S2 with valid=0.
REQ-014 SHALL extend operands to 33 bits (rs1 signed for MULH/MULHSU, rs2 signed for MULH only, else zero-extended), form 66-bit signed product.
REQ-015 SHALL deliver MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32].
REQ-016 SHALL split the product over S2-S4 (e.g. 17x17 partial products in S3, summed in S4); only S5-output equivalence to REQ-015 is required.
REQ-017 SHALL, with stall_i=1 and flush_i=0, hold every stage register unchanged and not sample inputs; wb_* stay stable.
REQ-018 SHALL, with flush_i=1, clear valid of S2, S3, S4 and not sample inputs at that edge; S5 advances normally (S5 <- S4 before clear is NOT done: S5 loads valid=0); flush beats stall.
REQ-019 SHALL, with neither stall nor flush, advance S2->S3->S4->S5 every edge; S5 is overwritten each edge (downstream takes wb_valid_o as single-cycle pulse per op).
REQ-020 SHALL drive wb_* directly from S5 registers; wb_write_data_o, addr, instruction, pc are don't-care-free: equal S5 contents even when wb_valid_o=0.
REQ-021 SHALL sustain one accepted op per cycle back-to-back with no bubbles.
REQ-022 SHALL drive stage_valid_o, stage_addr_o, busy_o combinationally from stage registers (no input dependency).

Reset
REQ-023 SHALL, while rsn_i=0, asynchronously clear all stage registers to 0: wb_valid_o=0, wb_write_addr_o=0, wb_write_data_o=0, wb_instruction_o=0, wb_pc_o=0, stage_valid_o=0, stage_addr_o=0, busy_o=0.
REQ-024 SHALL discard ops in flight when reset asserts mid-operation; first sample after release is at first rising edge with rsn_i=1.

Verification
REQ-025 MUL: rs1=0x00000007, rs2=0xFFFFFFFD, addr=5, valid at edge 0 -> after edge 3 wb_valid_o=1, addr=5, data=0xFFFFFFEB for one cycle.
REQ-026 High variants: rs1=rs2=0x80000000 -> MULH 0x40000000, MULHSU 0xC0000000, MULHU 0x40000000; rs1=0xFFFFFFFF rs2=2 MULHSU -> 0xFFFFFFFF.
REQ-027 Stall: op at edge 0, stall_i=1 for edges 1-2 -> wb_valid_o after edge 5, stage_valid_o frozen during stall, data unchanged.
REQ-028 Flush: ops at edges 0,1,2, flush_i=1 at edge 3 -> op0 writes back after edge 3 only if in S4 before flush per REQ-018 (expect none), no wb_valid_o in following 4 cycles, busy_o=0 after edge 3.
REQ-029 Back-to-back 8 random ops incl. op[2]=1 and valid=0 -> wb matches golden model in order, one per cycle, op[2]=1 never writes back.
REQ-030 Reset mid-flight: ops at edges 0,1, rsn_i low between edges 1-2 -> all outputs 0 immediately, no wb_valid_o after release.
